rx_disparity_checker: RTL and testbench

- Receive-side stage that consumes 10-bit code-groups from the deserializer/comma aligner and checks each one against the running disparity (RD) rules of IEEE 802.3 clause 36.
- Tracks RD per code-group and flags disparity and unbalanced-code errors.
- Acquires initial RD from a K28.5 comma and drops back to acquisition after repeated errors.
- Feeds the 8b/10b decoder and the PCS receive/sync state machine with registered code-groups, RD and error flags.

---
 rtl/pcs_8b10b_pkg.sv | 33 +++
 rtl/disparity_subblock_check.sv | 81 ++++++++
 rtl/rx_disparity_checker.sv | 191 +++++++++++++++++++
 tb/tb_rx_disparity_checker.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_8b10b_pkg.sv
// Shared 8b/10b PCS constants, FSM encoding and helpers.
// Used by the receive disparity checker and its sub-block checker.
package pcs_8b10b_pkg;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  typedef enum logic {
    SEEK  = 1'b0,
    TRACK = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic rd;
    logic disp_err;
    logic code_err;
  } sub_res_t;

  function automatic logic [2:0] ones6(
    input logic [5:0] v
  );
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/disparity_subblock_check.sv
// Running-disparity check of one 6b or 4b sub-block.
// Purely combinational; sel6 picks the 6-bit rules.
module disparity_subblock_check
  import pcs_8b10b_pkg::*;
(
  input  logic       rd_in,
  input  logic [5:0] sub_blk,
  input  logic       sel6,
  output logic       rd_next,
  output logic       disp_err,
  output logic       code_err
);

  logic [5:0] w_bits;
  logic [2:0] w_ones;
  logic [2:0] w_half;
  logic       w_hi;
  logic       w_lo;
  logic       w_p2;
  logic       w_m2;
  logic       w_sp_pos;
  logic       w_sp_neg;
  sub_res_t   w_res;

  assign w_bits = sel6 ? sub_blk
                       : {2'b00, sub_blk[3:0]};
  assign w_ones = ones6(w_bits);
  assign w_half = sel6 ? 3'd3 : 3'd2;

  assign w_hi = w_ones > (w_half + 3'd1);
  assign w_lo = (w_ones + 3'd1) < w_half;
  assign w_p2 = w_ones == (w_half + 3'd1);
  assign w_m2 = (w_ones + 3'd1) == w_half;

  assign w_sp_pos = sel6
    ? (sub_blk == 6'b000111)
    : (sub_blk[3:0] == 4'b0011);
  assign w_sp_neg = sel6
    ? (sub_blk == 6'b111000)
    : (sub_blk[3:0] == 4'b1100);

  // Unbalanced groups only raise code_err and
  // follow the ones majority for their RD.
  always_comb begin
    w_res = '{rd: rd_in,
              disp_err: 1'b0,
              code_err: 1'b0};
    unique case (1'b1)
      w_hi: begin
        w_res.code_err = 1'b1;
        w_res.rd       = RD_POS;
      end
      w_lo: begin
        w_res.code_err = 1'b1;
        w_res.rd       = RD_NEG;
      end
      w_p2: begin
        w_res.disp_err = rd_in != RD_NEG;
        w_res.rd       = RD_POS;
      end
      w_m2: begin
        w_res.disp_err = rd_in != RD_POS;
        w_res.rd       = RD_NEG;
      end
      w_sp_pos: begin
        w_res.disp_err = rd_in != RD_POS;
        w_res.rd       = RD_POS;
      end
      w_sp_neg: begin
        w_res.disp_err = rd_in != RD_NEG;
        w_res.rd       = RD_NEG;
      end
      default: ;
    endcase
  end

  assign rd_next  = w_res.rd;
  assign disp_err = w_res.disp_err;
  assign code_err = w_res.code_err;

endmodule

// File: rtl/rx_disparity_checker.sv
// Receive running-disparity checker with K28.5 RD acquisition.
// Define RX_DISP_ERR_CNT_EN to add the saturating err_count port.
module rx_disparity_checker
  import pcs_8b10b_pkg::*;
#(
  parameter int CG_WIDTH  = 10,
  parameter int ERR_LIMIT = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cg_valid,
  input  logic [CG_WIDTH-1:0] cg_in,
  output logic [CG_WIDTH-1:0] cg_out,
  output logic                cg_out_valid,
  output logic                rd_out,
  output logic                rd_locked,
  output logic                disp_err,
`ifdef RX_DISP_ERR_CNT_EN
  output logic                code_err,
  output logic [CNT_WIDTH-1:0] err_count
`else
  output logic                code_err
`endif
);

  if (CG_WIDTH != 10) begin : g_bad_cg
    $error("CG_WIDTH must be 10");
  end
  if (ERR_LIMIT < 1 || ERR_LIMIT > 15) begin : g_bad_lim
    $error("ERR_LIMIT must be 1..15");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("CNT_WIDTH must be >= 1");
  end

  localparam logic [3:0] LimM1 = 4'(ERR_LIMIT - 1);

  logic r_rst_meta;
  logic r_rst_sync;
  logic w_rst;

  // Reset asserts at once, releases two edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst = r_rst_sync;

  rd_state_e   r_state;
  rd_state_e   w_state_nx;
  logic        r_rd_cur;
  logic        w_rd_nx;
  logic [3:0]  r_consec;
  logic [3:0]  w_consec_nx;

  logic        w_rd6;
  logic        w_rd4;
  logic        w_de6;
  logic        w_de4;
  logic        w_ce6;
  logic        w_ce4;
  logic        w_pol;
  logic        w_unb;
  logic        w_comma_n;
  logic        w_comma_p;

  disparity_subblock_check u_sub6 (
    .rd_in    (r_rd_cur),
    .sub_blk  (cg_in[9:4]),
    .sel6     (1'b1),
    .rd_next  (w_rd6),
    .disp_err (w_de6),
    .code_err (w_ce6)
  );

  disparity_subblock_check u_sub4 (
    .rd_in    (w_rd6),
    .sub_blk  ({2'b00, cg_in[3:0]}),
    .sel6     (1'b0),
    .rd_next  (w_rd4),
    .disp_err (w_de4),
    .code_err (w_ce4)
  );

  assign w_pol     = w_de6 | w_de4;
  assign w_unb     = w_ce6 | w_ce4;
  assign w_comma_n = cg_in == K28_5_RDN;
  assign w_comma_p = cg_in == K28_5_RDP;

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_state  <= SEEK;
      r_rd_cur <= RD_NEG;
      r_consec <= 4'd0;
    end else begin
      r_state  <= w_state_nx;
      r_rd_cur <= w_rd_nx;
      r_consec <= w_consec_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_rd_nx     = r_rd_cur;
    w_consec_nx = r_consec;
    if (cg_valid) begin
      w_rd_nx = w_rd4;
      unique case (r_state)
        SEEK: begin
          if (w_comma_n) begin
            w_rd_nx    = RD_POS;
            w_state_nx = TRACK;
          end else if (w_comma_p) begin
            w_rd_nx    = RD_NEG;
            w_state_nx = TRACK;
          end
        end
        TRACK: begin
          if (w_pol | w_unb) begin
            if (r_consec == LimM1) begin
              w_state_nx  = SEEK;
              w_consec_nx = 4'd0;
            end else begin
              w_consec_nx = r_consec + 4'd1;
            end
          end else begin
            w_consec_nx = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  logic w_o_de;
  logic w_o_ce;
  logic w_o_lock;

  always_comb begin
    w_o_de   = 1'b0;
    w_o_ce   = 1'b0;
    w_o_lock = w_state_nx == TRACK;
    if (cg_valid) begin
      w_o_de = (r_state == TRACK) & w_pol;
      w_o_ce = w_unb;
    end
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      cg_out       <= '0;
      cg_out_valid <= 1'b0;
      rd_out       <= RD_NEG;
      rd_locked    <= 1'b0;
      disp_err     <= 1'b0;
      code_err     <= 1'b0;
    end else begin
      cg_out       <= cg_in;
      cg_out_valid <= cg_valid;
      rd_out       <= w_rd_nx;
      rd_locked    <= w_o_lock;
      disp_err     <= w_o_de;
      code_err     <= w_o_ce;
    end
  end

`ifdef RX_DISP_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic                 w_cnt_inc;

  assign w_cnt_inc = w_o_de | w_o_ce;

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_err_cnt <= '0;
    end else if (w_cnt_inc && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_rx_disparity_checker.sv
// Self-checking bench for rx_disparity_checker: vector table,
// hand sequences and random traffic against a rule-level model.
module tb_rx_disparity_checker;

  localparam int LIM   = 4;
  localparam int CNT_W = 2;
  localparam logic [9:0] KN = 10'b0011111010;
  localparam logic [9:0] KP = 10'b1100000101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cg_valid = 1'b0;
  logic [9:0] cg_in = '0;
  logic [9:0] cg_out;
  logic       cg_out_valid;
  logic       rd_out;
  logic       rd_locked;
  logic       disp_err;
  logic       code_err;
`ifdef RX_DISP_ERR_CNT_EN
  logic [CNT_W-1:0] err_count;
`endif

  always #5 clk = ~clk;

  rx_disparity_checker #(
    .CG_WIDTH  (10),
    .ERR_LIMIT (LIM),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cg_valid     (cg_valid),
    .cg_in        (cg_in),
    .cg_out       (cg_out),
    .cg_out_valid (cg_out_valid),
    .rd_out       (rd_out),
    .rd_locked    (rd_locked),
    .disp_err     (disp_err),
`ifdef RX_DISP_ERR_CNT_EN
    .code_err     (code_err),
    .err_count    (err_count)
`else
    .code_err     (code_err)
`endif
  );

  typedef struct {
    logic       v;
    logic [9:0] cg;
    logic       rd;
    logic       lk;
    logic       de;
    logic       ce;
    int         cnt;
  } exp_t;

  typedef struct {
    logic       v;
    logic [9:0] cg;
    logic       rd;
    logic       lk;
    logic       de;
    logic       ce;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;

  logic m_lock;
  logic m_rd;
  int   m_err;
  int   m_cnt;

  task automatic model_reset();
    m_lock = 1'b0;
    m_rd   = 1'b0;
    m_err  = 0;
    m_cnt  = 0;
  endtask

  // Disparity = 2*ones - width; rules stated on that number.
  task automatic sub_rule(input logic r, input int val,
                          input int n, output logic rn,
                          output logic de, output logic ce);
    int d;
    d  = 2 * $countones(val) - n;
    de = 1'b0;
    ce = 1'b0;
    rn = r;
    if (d > 2 || d < -2) begin
      ce = 1'b1;
      rn = d > 0;
    end else if (d == 2) begin
      de = r != 1'b0;
      rn = 1'b1;
    end else if (d == -2) begin
      de = r != 1'b1;
      rn = 1'b0;
    end else if ((n == 6 && val == 7) ||
                 (n == 4 && val == 3)) begin
      de = r != 1'b1;
      rn = 1'b1;
    end else if ((n == 6 && val == 56) ||
                 (n == 4 && val == 12)) begin
      de = r != 1'b0;
      rn = 1'b0;
    end
  endtask

  task automatic model_step(input logic v,
                            input logic [9:0] cg,
                            output exp_t e);
    logic r6, r4, d6, d4, c6, c4, pol;
    e.v  = v;
    e.cg = cg;
    e.de = 1'b0;
    e.ce = 1'b0;
    if (v) begin
      sub_rule(m_rd, int'(cg[9:4]), 6, r6, d6, c6);
      sub_rule(r6, int'(cg[3:0]), 4, r4, d4, c4);
      pol  = d6 | d4;
      e.ce = c6 | c4;
      m_rd = r4;
      if (!m_lock) begin
        if (cg == KN) begin
          m_rd = 1'b1;
          m_lock = 1'b1;
        end else if (cg == KP) begin
          m_rd = 1'b0;
          m_lock = 1'b1;
        end
      end else begin
        e.de = pol;
        if (pol | e.ce) begin
          m_err++;
          if (m_err == LIM) begin
            m_lock = 1'b0;
            m_err  = 0;
          end
        end else begin
          m_err = 0;
        end
      end
      if ((e.de | e.ce) && m_cnt < (1 << CNT_W) - 1)
        m_cnt++;
    end
    e.rd  = m_rd;
    e.lk  = m_lock;
    e.cnt = m_cnt;
  endtask

  task automatic cmp(input string nm, input exp_t e);
    n_vec++;
    if (cg_out_valid !== e.v) begin
      n_bad++;
      $display("FAIL %s valid got %b want %b",
               nm, cg_out_valid, e.v);
    end
    if (e.v && cg_out !== e.cg) begin
      n_bad++;
      $display("FAIL %s cg_out got %b want %b",
               nm, cg_out, e.cg);
    end
    if (rd_out !== e.rd) begin
      n_bad++;
      $display("FAIL %s rd_out got %b want %b",
               nm, rd_out, e.rd);
    end
    if (rd_locked !== e.lk) begin
      n_bad++;
      $display("FAIL %s rd_locked got %b want %b",
               nm, rd_locked, e.lk);
    end
    if (disp_err !== e.de) begin
      n_bad++;
      $display("FAIL %s disp_err got %b want %b",
               nm, disp_err, e.de);
    end
    if (code_err !== e.ce) begin
      n_bad++;
      $display("FAIL %s code_err got %b want %b",
               nm, code_err, e.ce);
    end
`ifdef RX_DISP_ERR_CNT_EN
    if (int'(err_count) != e.cnt) begin
      n_bad++;
      $display("FAIL %s err_count got %0d want %0d",
               nm, err_count, e.cnt);
    end
`endif
  endtask

  task automatic apply(input logic v, input logic [9:0] cg,
                       output exp_t e);
    cg_valid = v;
    cg_in    = cg;
    @(posedge clk);
    #1;
    model_step(v, cg, e);
  endtask

  task automatic do_reset();
    exp_t z;
    rst = 1'b1;
    cg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    model_reset();
    z = '{v: 0, cg: '0, rd: 0, lk: 0, de: 0, ce: 0, cnt: 0};
    cmp("reset", z);
  endtask

  vec_t tbl[18];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    string nm;
    logic v;
    logic [9:0] cg;

    tbl[0]  = '{1, 10'b0011111010, 1, 1, 0, 0};
    tbl[1]  = '{1, 10'b1001000101, 0, 1, 0, 0};
    tbl[2]  = '{1, 10'b1101010101, 1, 1, 0, 0};
    tbl[3]  = '{1, 10'b1101010101, 1, 1, 1, 0};
    tbl[4]  = '{0, 10'b1111111111, 1, 1, 0, 0};
    tbl[5]  = '{1, 10'b1001000101, 0, 1, 0, 0};
    tbl[6]  = '{1, 10'b1111110000, 0, 1, 0, 1};
    tbl[7]  = '{1, 10'b1100000101, 0, 1, 1, 0};
    tbl[8]  = '{1, 10'b0011111010, 1, 1, 0, 0};
    tbl[9]  = '{1, 10'b1010100011, 1, 1, 0, 0};
    tbl[10] = '{1, 10'b1010101100, 0, 1, 1, 0};
    tbl[11] = '{1, 10'b1110000101, 0, 1, 0, 0};
    tbl[12] = '{1, 10'b0001110101, 1, 1, 1, 0};
    tbl[13] = '{1, 10'b1101010101, 1, 1, 1, 0};
    tbl[14] = '{1, 10'b1101010101, 1, 1, 1, 0};
    tbl[15] = '{1, 10'b1101010101, 1, 0, 1, 0};
    tbl[16] = '{1, 10'b1101010101, 1, 0, 0, 0};
    tbl[17] = '{1, 10'b1100000101, 0, 1, 0, 0};

    do_reset();

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].v, tbl[i].cg, e);
      e.v  = tbl[i].v;
      e.rd = tbl[i].rd;
      e.lk = tbl[i].lk;
      e.de = tbl[i].de;
      e.ce = tbl[i].ce;
      nm = $sformatf("tbl%0d", i);
      cmp(nm, e);
    end

    apply(1'b1, 10'b1101010101, e);
    cmp("pre_hold", e);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 10'(i * 77), e);
      cmp("hold", e);
    end
    apply(1'b1, 10'b1001000101, e);
    cmp("post_hold", e);

    cg_valid = 1'b1;
    cg_in = 10'b1111110000;
    @(negedge clk);
    rst = 1'b1;
    #1;
    e = '{v: 0, cg: '0, rd: 0, lk: 0, de: 0, ce: 0, cnt: 0};
    cmp("async_rst", e);
    do_reset();

    apply(1'b1, 10'b1111110000, e);
    cmp("seek_code_err", e);
    apply(1'b1, 10'b1100000101, e);
    cmp("relock_rdp", e);

    for (int i = 0; i < 400; i++) begin
      v = $urandom_range(0, 9) != 0;
      case ($urandom_range(0, 7))
        0: cg = KN;
        1: cg = KP;
        2: cg = 10'b1001000101;
        3: cg = 10'b0110111010;
        default: cg = 10'($urandom);
      endcase
      apply(v, cg, e);
      nm = $sformatf("rnd%0d", i);
      cmp(nm, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
